xst_tx: RTL and testbench
=========================

XST_TX -- requirements
Module: xst_tx

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have port bits_i  input  6  bits per frame including start/stop, sampled at load.
REQ-004 SHALL have port baud_i  input  64  bit period minus one, in clk_i cycles.
REQ-005 SHALL have port dat_i  input  64  frame to send, LSB first, sampled at load.
REQ-006 SHALL have port txreg_we_i  input  1  load strobe.
REQ-007 SHALL have port txreg_oe_i  input  1  read enable for dat_o.
REQ-008 SHALL have port dat_o  output  64  shift register contents when txreg_oe_i=1, else 0.
REQ-009 SHALL have port txd_o  output  1  serial data, idles high.
REQ-010 SHALL have port txc_o  output  1  bit-centre clock, idles high.
REQ-011 SHALL have port idle_o  output  1  high when bitsLeft==0.
REQ-012 SHALL have port shift_to  output  1  one-cycle strobe on each bit shift.

Function
REQ-013 SHALL hold state: shiftReg[63:0], bitsLeft[5:0], baudCtr[63:0].
REQ-014 States SHALL be IDLE (bitsLeft==0) and SEND (bitsLeft!=0); idle_o combinational from bitsLeft.
REQ-015 IDLE + txreg_we_i=1 + bits_i!=0 SHALL load shiftReg<=dat_i, bitsLeft<=bits_i, baudCtr<=baud_i; SEND from next cycle.
REQ-016 IDLE + txreg_we_i=1 + bits_i==0 SHALL be ignored; no state changes.
REQ-017 txreg_we_i during SEND SHALL be ignored; frame in flight not disturbed.
REQ-018 In IDLE without load, baudCtr SHALL be reloaded with baud_i every cycle.
REQ-019 In SEND with baudCtr!=0, baudCtr SHALL decrement by 1.
REQ-020 In SEND with baudCtr==0: shiftReg<={1'b1, shiftReg[63:1]}, bitsLeft<=bitsLeft-1, baudCtr<=baud_i, shift_to=1 that cycle.
REQ-021 shift_to SHALL be combinational: ~idle_o && baudCtr==0.
REQ-022 Each bit SHALL last exactly baud_i+1 cycles; frame lasts bits_i*(baud_i+1) cycles.
REQ-023 txd_o SHALL be registered: shiftReg[0]-equivalent value of the next state when SEND, 1 when IDLE; first bit appears the cycle after load.
REQ-024 txd_o SHALL return to 1 in the cycle after the final shift.
REQ-025 baudCtr and baud_i arithmetic SHALL be unsigned 64-bit; baud_i=0 gives one-cycle bits.
REQ-026 Half-point for txc_o SHALL be {1'b0, baud_i[63:1]}, i.e. baud_i>>1.

Reset
REQ-027 reset_i=1 SHALL force shiftReg=all ones, bitsLeft=0, baudCtr=baud_i, txd_o=1, txc_o=1, ignoring txreg_we_i.
REQ-028 Reset SHALL take priority over load and shift, and abort a frame mid-bit; outputs idle next cycle.
REQ-029 After reset: idle_o=1, shift_to=0, dat_o=0 if txreg_oe_i=0 else all ones.

Configuration
REQ-030 Macro XST_TX_TXC_EN SHALL gate the bit-centre clock output.
REQ-031 With XST_TX_TXC_EN defined: txc_o registered, 0 in SEND while baudCtr>baud_i>>1, 1 otherwise, rising once per bit at its midpoint.
REQ-032 Without XST_TX_TXC_EN: txc_o SHALL be constant 1, no txc logic generated; other behaviour unchanged.

Verification
REQ-033 Reset, baud_i=3, bits_i=10, load dat_i=0x2A5 -> txd_o = 1,0,1,0,0,1,0,1,0,1 LSB first, 4 cycles each, idle_o rises after 40 cycles.
REQ-034 baud_i=0, bits_i=1, load dat_i=0x0 -> txd_o low exactly 1 cycle, shift_to pulses once, idle_o high again.
REQ-035 Mid-frame txreg_we_i with dat_i=0xFF -> ignored, original frame completes unchanged.
REQ-036 Load with bits_i=0 -> idle_o stays 1, dat_o (oe=1) unchanged all ones, txd_o stays 1.
REQ-037 reset_i asserted at bit 3 of 10 -> next cycle txd_o=1, idle_o=1, shiftReg all ones.
REQ-038 XST_TX_TXC_EN, baud_i=7 -> txc_o low 4 cycles then high 4 cycles per bit; undefined -> txc_o constantly 1.

Source files
------------

// File: rtl/xst_tx.sv
// Serial frame transmitter: shifts a loaded frame out LSB first, one bit every baud_i+1 cycles.
// Optional bit-centre clock on txc_o is built only when XST_TX_TXC_EN is defined.
module xst_tx (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  bits_i,
    input  logic [63:0] baud_i,
    input  logic [63:0] dat_i,
    input  logic        txreg_we_i,
    input  logic        txreg_oe_i,
    output logic [63:0] dat_o,
    output logic        txd_o,
    output logic        txc_o,
    output logic        idle_o,
    output logic        shift_to
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      w_state;
    logic [63:0] r_shift_reg;
    logic [5:0]  r_bits_left;
    logic [63:0] r_baud_ctr;
    logic        r_txd;
    logic [63:0] w_shift_nxt;
    logic [5:0]  w_bits_nxt;
    logic [63:0] w_baud_nxt;
    logic        w_shift;

    // The state is implied by the remaining bit count rather than stored separately.
    assign w_state  = (r_bits_left == 6'd0) ? ST_IDLE : ST_SEND;
    assign w_shift  = (w_state == ST_SEND) && (r_baud_ctr == 64'd0);
    assign idle_o   = (w_state == ST_IDLE);
    assign shift_to = w_shift;
    assign dat_o    = txreg_oe_i ? r_shift_reg : 64'd0;
    assign txd_o    = r_txd;

    // Next-state: load in idle, count down the bit period in send, shift at period end.
    always_comb begin
        w_shift_nxt = r_shift_reg;
        w_bits_nxt  = r_bits_left;
        w_baud_nxt  = r_baud_ctr;
        case (w_state)
            ST_IDLE: begin
                if (txreg_we_i && (bits_i != 6'd0)) begin
                    w_shift_nxt = dat_i;
                    w_bits_nxt  = bits_i;
                    w_baud_nxt  = baud_i;
                end else begin
                    w_baud_nxt  = baud_i;
                end
            end
            ST_SEND: begin
                if (w_shift) begin
                    w_shift_nxt = {1'b1, r_shift_reg[63:1]};
                    w_bits_nxt  = r_bits_left - 6'd1;
                    w_baud_nxt  = baud_i;
                end else begin
                    w_baud_nxt  = r_baud_ctr - 64'd1;
                end
            end
            default: begin
                w_bits_nxt = 6'd0;
                w_baud_nxt = baud_i;
            end
        endcase
    end

    // State register; txd_o is taken from the next state so the first bit shows right after load.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_shift_reg <= {64{1'b1}};
            r_bits_left <= 6'd0;
            r_baud_ctr  <= baud_i;
            r_txd       <= 1'b1;
        end else begin
            r_shift_reg <= w_shift_nxt;
            r_bits_left <= w_bits_nxt;
            r_baud_ctr  <= w_baud_nxt;
            r_txd       <= (w_bits_nxt != 6'd0) ? w_shift_nxt[0] : 1'b1;
        end
    end

`ifdef XST_TX_TXC_EN
    logic r_txc;

    // Low during the first half of each bit, rising at the bit midpoint.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_txc <= 1'b1;
        end else begin
            r_txc <= ~((w_bits_nxt != 6'd0) && (w_baud_nxt > {1'b0, baud_i[63:1]}));
        end
    end

    assign txc_o = r_txc;
`else
    assign txc_o = 1'b1;
`endif

endmodule

// File: tb/tb_xst_tx.sv
// Self-checking bench for xst_tx: directed scenarios plus randomized back-to-back frames
// checked cycle by cycle against a waveform model computed from bit period arithmetic.
module tb_xst_tx;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [5:0]  bits_i;
    logic [63:0] baud_i;
    logic [63:0] dat_i;
    logic        txreg_we_i;
    logic        txreg_oe_i;
    logic [63:0] dat_o;
    logic        txd_o;
    logic        txc_o;
    logic        idle_o;
    logic        shift_to;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    xst_tx dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .bits_i     (bits_i),
        .baud_i     (baud_i),
        .dat_i      (dat_i),
        .txreg_we_i (txreg_we_i),
        .txreg_oe_i (txreg_oe_i),
        .dat_o      (dat_o),
        .txd_o      (txd_o),
        .txc_o      (txc_o),
        .idle_o     (idle_o),
        .shift_to   (shift_to)
    );

    // Reference model: c counts cycles from the first cycle after the load edge, per = baud+1.
    function automatic logic m_txd(input logic [63:0] d, input int nb, input int per, input int c);
        if (c >= nb * per) return 1'b1;
        return d[c / per];
    endfunction

    function automatic logic m_shift(input int nb, input int per, input int c);
        return (c < nb * per) && ((c % per) == per - 1);
    endfunction

    function automatic logic [63:0] m_sreg(input logic [63:0] d, input int nb, input int per, input int c);
        logic [63:0] ones;
        int k;
        ones = {64{1'b1}};
        k = c / per;
        if (k > nb) k = nb;
        return (d >> k) | ~(ones >> k);
    endfunction

    function automatic logic m_txc(input int nb, input int per, input int c);
`ifdef XST_TX_TXC_EN
        int ctr;
        if (c >= nb * per) return 1'b1;
        ctr = (per - 1) - (c % per);
        return !(ctr > (per - 1) / 2);
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [5:0] b, input logic [63:0] d);
        bits_i     = b;
        dat_i      = d;
        txreg_we_i = 1'b1;
        tick();
        txreg_we_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i    = 1'b1;
        txreg_we_i = 1'b1;
        bits_i     = 6'd5;
        dat_i      = 64'h0;
        txreg_oe_i = 1'b0;
        tick();
        tick();
        txreg_we_i = 1'b0;
        n_checks++; if (idle_o !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle_o); else n_pass++;
        n_checks++; if (shift_to !== 1'b0) $display("FAIL reset_shift got %b exp 0", shift_to); else n_pass++;
        n_checks++; if (txd_o !== 1'b1) $display("FAIL reset_txd got %b exp 1", txd_o); else n_pass++;
        n_checks++; if (txc_o !== 1'b1) $display("FAIL reset_txc got %b exp 1", txc_o); else n_pass++;
        n_checks++; if (dat_o !== 64'd0) $display("FAIL reset_dat_oe0 got %h exp 0", dat_o); else n_pass++;
        txreg_oe_i = 1'b1;
        #1;
        n_checks++; if (dat_o !== {64{1'b1}}) $display("FAIL reset_dat_oe1 got %h exp all ones", dat_o); else n_pass++;
        reset_i = 1'b0;
        tick();
        n_checks++; if (idle_o !== 1'b1) $display("FAIL reset_release_idle got %b exp 1", idle_o); else n_pass++;
    endtask

    task automatic test_spec_frame;
        logic exp_seq [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic e;
        baud_i = 64'd3;
        load(6'd10, 64'h2A5);
        for (int c = 0; c <= 40; c++) begin
            e = (c < 40) ? exp_seq[c / 4] : 1'b1;
            n_checks++; if (txd_o !== e) $display("FAIL spec_txd c=%0d got %b exp %b", c, txd_o, e); else n_pass++;
            n_checks++; if (idle_o !== (c >= 40)) $display("FAIL spec_idle c=%0d got %b exp %b", c, idle_o, c >= 40); else n_pass++;
            if (c < 40) tick();
        end
    endtask

    task automatic test_single_bit;
        int pulses = 0;
        baud_i = 64'd0;
        load(6'd1, 64'h0);
        n_checks++; if (txd_o !== 1'b0) $display("FAIL one_txd0 got %b exp 0", txd_o); else n_pass++;
        n_checks++; if (idle_o !== 1'b0) $display("FAIL one_idle0 got %b exp 0", idle_o); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            if (shift_to === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (pulses != 1) $display("FAIL one_pulses got %0d exp 1", pulses); else n_pass++;
        n_checks++; if (txd_o !== 1'b1) $display("FAIL one_txd_end got %b exp 1", txd_o); else n_pass++;
        n_checks++; if (idle_o !== 1'b1) $display("FAIL one_idle_end got %b exp 1", idle_o); else n_pass++;
    endtask

    task automatic test_load_during_send;
        logic [63:0] d;
        int per, nb;
        per = 3;
        nb  = 12;
        d   = {$urandom, $urandom};
        baud_i     = 64'd2;
        txreg_oe_i = 1'b1;
        load(nb[5:0], d);
        for (int c = 0; c <= nb * per; c++) begin
            n_checks++; if (txd_o !== m_txd(d, nb, per, c)) $display("FAIL busy_txd c=%0d got %b exp %b", c, txd_o, m_txd(d, nb, per, c)); else n_pass++;
            n_checks++; if (dat_o !== m_sreg(d, nb, per, c)) $display("FAIL busy_dat c=%0d got %h exp %h", c, dat_o, m_sreg(d, nb, per, c)); else n_pass++;
            n_checks++; if (idle_o !== (c >= nb * per)) $display("FAIL busy_idle c=%0d got %b exp %b", c, idle_o, c >= nb * per); else n_pass++;
            txreg_we_i = (c >= 5 && c <= 7);
            dat_i      = 64'hFF;
            bits_i     = 6'd8;
            if (c < nb * per) tick();
        end
        txreg_we_i = 1'b0;
    endtask

    task automatic test_zero_bits;
        reset_i = 1'b1;
        tick();
        reset_i    = 1'b0;
        txreg_oe_i = 1'b1;
        load(6'd0, {$urandom, $urandom});
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (idle_o !== 1'b1) $display("FAIL zero_idle c=%0d got %b exp 1", c, idle_o); else n_pass++;
            n_checks++; if (txd_o !== 1'b1) $display("FAIL zero_txd c=%0d got %b exp 1", c, txd_o); else n_pass++;
            n_checks++; if (dat_o !== {64{1'b1}}) $display("FAIL zero_dat c=%0d got %h exp all ones", c, dat_o); else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_abort;
        baud_i     = 64'd3;
        txreg_oe_i = 1'b1;
        load(6'd10, 64'h0);
        for (int c = 0; c < 13; c++) tick();
        n_checks++; if (idle_o !== 1'b0) $display("FAIL abort_busy got %b exp 0", idle_o); else n_pass++;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n_checks++; if (txd_o !== 1'b1) $display("FAIL abort_txd got %b exp 1", txd_o); else n_pass++;
        n_checks++; if (idle_o !== 1'b1) $display("FAIL abort_idle got %b exp 1", idle_o); else n_pass++;
        n_checks++; if (dat_o !== {64{1'b1}}) $display("FAIL abort_sreg got %h exp all ones", dat_o); else n_pass++;
        n_checks++; if (shift_to !== 1'b0) $display("FAIL abort_shift got %b exp 0", shift_to); else n_pass++;
    endtask

    task automatic test_txc;
        int per, nb;
        logic [63:0] d;
        per = 8;
        nb  = 3;
        d   = {$urandom, $urandom};
        baud_i = 64'd7;
        tick();
        load(nb[5:0], d);
        for (int c = 0; c <= nb * per; c++) begin
            n_checks++; if (txc_o !== m_txc(nb, per, c)) $display("FAIL txc c=%0d got %b exp %b", c, txc_o, m_txc(nb, per, c)); else n_pass++;
            if (c < nb * per) tick();
        end
    endtask

    task automatic test_back_to_back;
        int per, nb;
        logic [63:0] d;
        for (int f = 0; f < 20; f++) begin
            per        = $urandom_range(1, 4);
            nb         = $urandom_range(1, 63);
            d          = {$urandom, $urandom};
            baud_i     = 64'(per - 1);
            txreg_oe_i = $urandom_range(0, 1);
            load(nb[5:0], d);
            for (int c = 0; c <= nb * per; c++) begin
                n_checks++; if (txd_o !== m_txd(d, nb, per, c)) $display("FAIL rnd_txd f=%0d c=%0d got %b exp %b", f, c, txd_o, m_txd(d, nb, per, c)); else n_pass++;
                n_checks++; if (shift_to !== m_shift(nb, per, c)) $display("FAIL rnd_shift f=%0d c=%0d got %b exp %b", f, c, shift_to, m_shift(nb, per, c)); else n_pass++;
                n_checks++; if (idle_o !== (c >= nb * per)) $display("FAIL rnd_idle f=%0d c=%0d got %b exp %b", f, c, idle_o, c >= nb * per); else n_pass++;
                n_checks++; if (txc_o !== m_txc(nb, per, c)) $display("FAIL rnd_txc f=%0d c=%0d got %b exp %b", f, c, txc_o, m_txc(nb, per, c)); else n_pass++;
                n_checks++;
                if (dat_o !== (txreg_oe_i ? m_sreg(d, nb, per, c) : 64'd0))
                    $display("FAIL rnd_dat f=%0d c=%0d got %h exp %h", f, c, dat_o, txreg_oe_i ? m_sreg(d, nb, per, c) : 64'd0);
                else n_pass++;
                if (c < nb * per) tick();
            end
        end
    endtask

    initial begin
        reset_i    = 1'b1;
        bits_i     = 6'd0;
        baud_i     = 64'd3;
        dat_i      = 64'd0;
        txreg_we_i = 1'b0;
        txreg_oe_i = 1'b0;
        test_reset();
        test_spec_frame();
        test_single_bit();
        test_load_during_send();
        test_zero_bits();
        test_reset_abort();
        test_txc();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
